sub_share_arb: RTL and testbench

//  Shares one instance of the fixed-latency 8-bit datapath unit `sub` between NUM_REQ requesters.

---
 rtl/sub_share_arb_pkg.sv | 28 ++
 rtl/sub_share_arb_rr_pick.sv | 33 +++
 rtl/sub_share_arb.sv | 163 ++++++++++++++++
 tb/tb_sub_share_arb.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sub_share_arb_pkg.sv
// Shared types and helpers for sub_share_arb: FSM state, issue tag, index arithmetic.
package sub_share_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int ID_W    = $clog2(MAX_REQ);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    LOCK,
    DRAIN
  } state_e;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  // (a + b) mod n for a < n and 0 <= b < n
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a, input int b,
                                               input int n);
    int s;
    s = int'(a) + b;
    if (s >= n) s = s - n;
    return s[ID_W-1:0];
  endfunction

endpackage

// File: rtl/sub_share_arb_rr_pick.sv
// Combinational rotate-priority picker: first valid requester at or after ptr, wrapping.
module sub_share_arb_rr_pick
  import sub_share_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [2*NUM_REQ-1:0] dbl;

  // Rotating the doubled vector puts requester ptr at bit 0, so the lowest set bit wins.
  always_comb begin
    dbl   = {valid, valid} >> ptr;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any && dbl[k]) begin
        any = 1'b1;
        idx = wrap_add(ptr, k, NUM_REQ);
      end
    end
    if (any) grant = ONE << idx;
  end

endmodule

// File: rtl/sub_share_arb.sv
// Shares one fixed-latency sub unit between NUM_REQ requesters with round-robin, burst lock,
// tag-steered responses and flush/drain. Optional counters: SUB_SHARE_ARB_PERF_EN.
module sub_share_arb
  import sub_share_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8,
  parameter int SUB_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         sub_data_in,
  input  logic [DATA_W-1:0]         sub_data_out,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic                      flush_req,
  output logic                      flush_done,
  output state_e                    fsm_state
`ifdef SUB_SHARE_ARB_PERF_EN
  ,
  output logic [15:0]               perf_cnt [NUM_REQ+1]
`endif
);

  // Handshake: an issue happens in a cycle where req_valid[i] & req_ready[i]; req_ready is
  // one-hot, never set without req_valid, never set while flush_req is high or in DRAIN.

  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_e              state, state_nxt;
  logic [ID_W-1:0]     owner, owner_nxt;
  logic [ID_W-1:0]     rr_ptr, ptr_nxt;
  logic [NUM_REQ-1:0]  pick_grant;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_any;
  logic [NUM_REQ-1:0]  owner_oh;
  logic                issue;
  logic                issue_lock;
  logic [ID_W-1:0]     issue_idx;
  logic [DATA_W-1:0]   issue_data;
  tag_t                pipe [SUB_LAT+1];
  logic                busy;

  sub_share_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    owner_oh  = ONE << owner;
    req_ready = '0;
    if (!flush_req) begin
      case (state)
        IDLE, RUN: if (pick_any) req_ready = pick_grant;
        LOCK:      req_ready = req_valid & owner_oh;
        default:   req_ready = '0;
      endcase
    end
    issue      = |req_ready;
    issue_lock = |(req_ready & req_lock);
    issue_idx  = (state == LOCK) ? owner : pick_idx;
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = rr_ptr;
    if (flush_req) begin
      state_nxt = DRAIN;
    end else begin
      case (state)
        IDLE, RUN: begin
          if (issue) begin
            ptr_nxt = wrap_add(pick_idx, 1, NUM_REQ);
            if (issue_lock) begin
              state_nxt = LOCK;
              owner_nxt = pick_idx;
            end else begin
              state_nxt = RUN;
            end
          end else begin
            state_nxt = IDLE;
          end
        end
        LOCK: begin
          // Lock ends on an unlocked owner beat or when the owner drops valid (no issue then).
          if (!(|(req_valid & owner_oh)) || (issue && !issue_lock)) begin
            state_nxt = RUN;
            ptr_nxt   = wrap_add(owner, 1, NUM_REQ);
          end
        end
        DRAIN:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= ptr_nxt;
    end
  end

  always_comb begin
    issue_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) issue_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Stage 0 lines up with sub_data_in, stage SUB_LAT with sub_data_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_data_in <= '0;
      for (int k = 0; k <= SUB_LAT; k++) pipe[k] <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      if (issue) sub_data_in <= issue_data;
      pipe[0] <= {issue, issue_idx};
      for (int k = 1; k <= SUB_LAT; k++) pipe[k] <= pipe[k-1];
      rsp_valid <= pipe[SUB_LAT].vld ? (ONE << pipe[SUB_LAT].id) : '0;
      if (pipe[SUB_LAT].vld) rsp_data <= sub_data_out;
    end
  end

  // The response register counts as in flight so flush_done trails the last rsp_valid.
  always_comb begin
    busy = |rsp_valid;
    for (int k = 0; k <= SUB_LAT; k++) busy = busy | pipe[k].vld;
  end

  assign flush_done = (state == DRAIN) && !busy;
  assign fsm_state  = state;

`ifdef SUB_SHARE_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NUM_REQ; i++) perf_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && perf_cnt[i] != 16'hFFFF) perf_cnt[i] <= perf_cnt[i] + 16'd1;
      end
      if ((|req_valid) && !issue && perf_cnt[NUM_REQ] != 16'hFFFF)
        perf_cnt[NUM_REQ] <= perf_cnt[NUM_REQ] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sub_share_arb.sv
// Bench for sub_share_arb (NUM_REQ=2, SUB_LAT=1) with a behavioural sub unit and a
// response scoreboard keyed on expected arrival cycle.
module tb_sub_share_arb;
  import sub_share_arb_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 8;
  localparam int SUB_LAT = 1;
  localparam int LAT     = SUB_LAT + 2;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b1;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_lock = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         sub_data_in;
  logic [DATA_W-1:0]         sub_data_out;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      flush_req = 1'b0;
  logic                      flush_done;
  state_e                    fsm_state;
`ifdef SUB_SHARE_ARB_PERF_EN
  logic [15:0]               perf_cnt [NUM_REQ+1];
`endif

  sub_share_arb #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .SUB_LAT(SUB_LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_lock     (req_lock),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .sub_data_in  (sub_data_in),
    .sub_data_out (sub_data_out),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .flush_req    (flush_req),
    .flush_done   (flush_done),
    .fsm_state    (fsm_state)
`ifdef SUB_SHARE_ARB_PERF_EN
    ,
    .perf_cnt     (perf_cnt)
`endif
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural sub unit ----------------
  function automatic logic [7:0] sub_fn(input logic [7:0] x);
    return {x[3:0], x[7:4]} ^ 8'h5A;
  endfunction

  logic [7:0] sub_q;
  always @(posedge clk) sub_q <= sub_fn(sub_data_in);
  assign sub_data_out = sub_q;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // entry: {due cycle[31:16], one-hot id[15:8], data[7:0]}
  logic [31:0] exp_q[$];
  logic [31:0] e;
  bit          mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() != 0 && exp_q[0][31:16] == cyc[15:0]) begin
        e = exp_q.pop_front();
        chk("rsp_valid", {30'd0, rsp_valid}, {24'd0, e[15:8]});
        chk("rsp_data", {24'd0, rsp_data}, {24'd0, e[7:0]});
      end else begin
        chk("rsp_quiet", {30'd0, rsp_valid}, 32'd0);
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1; drives one cycle, checks ready/flush_done, returns at next posedge+1.
  task automatic step(input logic [1:0] v, input logic [1:0] lk, input logic fl,
                      input logic [7:0] d0, input logic [7:0] d1,
                      input logic [1:0] rdy, input logic done);
    req_valid = v;
    req_lock  = lk;
    flush_req = fl;
    req_data  = {d1, d0};
    @(negedge clk);
    chk("req_ready", {30'd0, req_ready}, {30'd0, rdy});
    chk("flush_done", {31'd0, flush_done}, {31'd0, done});
    if (rdy[0]) exp_q.push_back({16'(cyc + LAT), 8'h01, sub_fn(d0)});
    if (rdy[1]) exp_q.push_back({16'(cyc + LAT), 8'h02, sub_fn(d1)});
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rnd();
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 2'b00, 1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
  endtask

  task automatic do_reset();
    req_valid = '0;
    req_lock  = '0;
    flush_req = 1'b0;
    mon_en    = 1'b0;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_sub_data_in", {24'd0, sub_data_in}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    chk("rst_flush_done", {31'd0, flush_done}, 32'd0);
    chk("rst_state", {30'd0, fsm_state}, {30'd0, IDLE});
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0] v;
    logic [1:0] lk;
    logic       fl;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] rdy;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                              input logic [1:0] rdy);
    vec_t r;
    r.v = v; r.lk = 2'b00; r.fl = 1'b0; r.d0 = d0; r.d1 = d1; r.rdy = rdy; r.done = 1'b0;
    return r;
  endfunction

  initial begin
    // single requester 0 with 8'h3C from reset (pointer 0)
    vecs.push_back(mk(2'b01, 8'h3C, 8'h00, 2'b01));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(2'b00, 8'h00, 8'h00, 2'b00));
    // pointer now 1: lone requester 1, then both valid for 8 cycles alternate 0,1,...
    vecs.push_back(mk(2'b10, rnd(), rnd(), 2'b10));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(2'b11, rnd(), rnd(), (i % 2 == 0) ? 2'b01 : 2'b10));
    // pointer 0: search wraps to requester 1, then back to 0
    vecs.push_back(mk(2'b10, rnd(), rnd(), 2'b10));
    vecs.push_back(mk(2'b01, rnd(), rnd(), 2'b01));
    vecs.push_back(mk(2'b00, 8'h00, 8'h00, 2'b00));

    rst_n = 1'b1;
    #1;
    do_reset();

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].v, vecs[i].lk, vecs[i].fl, vecs[i].d0, vecs[i].d1, vecs[i].rdy, vecs[i].done);

    // burst lock: requester 1 holds three beats while requester 0 waits (pointer is 1)
    step(2'b11, 2'b10, 1'b0, rnd(), rnd(), 2'b10, 1'b0);
    step(2'b11, 2'b10, 1'b0, rnd(), rnd(), 2'b10, 1'b0);
    step(2'b11, 2'b00, 1'b0, rnd(), rnd(), 2'b10, 1'b0);
    step(2'b11, 2'b00, 1'b0, rnd(), rnd(), 2'b01, 1'b0);
    idle(1);

    // lock owner drops valid: release with no issue, pointer moves to 0
    step(2'b10, 2'b10, 1'b0, rnd(), rnd(), 2'b10, 1'b0);
    step(2'b01, 2'b00, 1'b0, rnd(), rnd(), 2'b00, 1'b0);
    step(2'b01, 2'b00, 1'b0, rnd(), rnd(), 2'b01, 1'b0);
    idle(1);

    // flush with two in flight (pointer is 1)
    step(2'b11, 2'b00, 1'b0, rnd(), rnd(), 2'b10, 1'b0);
    step(2'b11, 2'b00, 1'b0, rnd(), rnd(), 2'b01, 1'b0);
    step(2'b11, 2'b00, 1'b1, rnd(), rnd(), 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b1, rnd(), rnd(), 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b1, rnd(), rnd(), 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b1, rnd(), rnd(), 2'b00, 1'b1);
    step(2'b11, 2'b00, 1'b1, rnd(), rnd(), 2'b00, 1'b1);
    step(2'b00, 2'b00, 1'b0, 8'h00, 8'h00, 2'b00, 1'b1);
    step(2'b00, 2'b00, 1'b0, 8'h00, 8'h00, 2'b00, 1'b0);

    // reset during traffic: nothing in flight may surface afterwards
    step(2'b11, 2'b00, 1'b0, rnd(), rnd(), 2'b10, 1'b0);
    step(2'b11, 2'b00, 1'b0, rnd(), rnd(), 2'b01, 1'b0);
    do_reset();
    idle(4);
    step(2'b11, 2'b00, 1'b0, rnd(), rnd(), 2'b01, 1'b0);
    idle(4);

`ifdef SUB_SHARE_ARB_PERF_EN
    do_reset();
    for (int i = 0; i < 5; i++) step(2'b01, 2'b00, 1'b0, rnd(), 8'h00, 2'b01, 1'b0);
    for (int i = 0; i < 3; i++) step(2'b01, 2'b00, 1'b1, rnd(), 8'h00, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b0, 8'h00, 8'h00, 2'b00, 1'b1);
    idle(2);
    chk("perf_issue0", {16'd0, perf_cnt[0]}, 32'd5);
    chk("perf_issue1", {16'd0, perf_cnt[1]}, 32'd0);
    chk("perf_stall", {16'd0, perf_cnt[NUM_REQ]}, 32'd3);
`endif

    idle(2);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
